ftdi_fifo_bridge: RTL and testbench

Parametrised buffering bridge between the FTDI byte controller's four-phase req/ack handshakes and a streaming valid/ready user interface. It is the successor to the direct controller-to-handler wiring. It adds an RX FIFO and a TX FIFO of configurable width and depth, level reporting, and watermark-based RX flow control on the controller's receive-enable input. It sits between `ftdiController` and the packet/command handler in the top level, all on the main clock.

---
 rtl/ftdi_fifo_bridge.sv | 181 ++++++++++++++++++
 tb/tb_ftdi_fifo_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_fifo_bridge.sv
// Buffering bridge between the FTDI controller's four-phase req/ack handshakes
// and a valid/ready user stream, with RX/TX FIFOs and RX watermark flow control.
module ftdi_fifo_bridge #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned RX_DEPTH_LOG2   = 4,
  parameter int unsigned TX_DEPTH_LOG2   = 4,
  parameter int unsigned RX_AFULL_MARGIN = 2
) (
  input  logic                   in_clk,
  input  logic                   in_reset_n,
  input  logic                   in_rx_hsk_req,
  input  logic [DATA_W-1:0]      in_rx_data,
  output logic                   out_rx_hsk_ack,
  output logic                   out_rx_en,
  output logic                   out_tx_hsk_req,
  output logic [DATA_W-1:0]      out_tx_data,
  input  logic                   in_tx_hsk_ack,
  output logic                   out_rx_valid,
  output logic [DATA_W-1:0]      out_rx_data,
  input  logic                   in_rx_ready,
  input  logic                   in_tx_valid,
  input  logic [DATA_W-1:0]      in_tx_data,
  output logic                   out_tx_ready,
  output logic [RX_DEPTH_LOG2:0] out_rx_level,
  output logic [TX_DEPTH_LOG2:0] out_tx_level
);

  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int unsigned RX_PW    = RX_DEPTH_LOG2;
  localparam int unsigned TX_PW    = TX_DEPTH_LOG2;
  localparam int unsigned RX_CW    = RX_DEPTH_LOG2 + 1;
  localparam int unsigned TX_CW    = TX_DEPTH_LOG2 + 1;
  localparam logic        RX_EN_RST = (RX_AFULL_MARGIN < RX_DEPTH);

  typedef enum logic       {R_IDLE, R_ACK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_DONE} tx_state_t;

  logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
  logic [RX_PW-1:0]  r_rx_wr_ptr, r_rx_rd_ptr;
  logic [RX_CW-1:0]  r_rx_count;
  logic [RX_CW-1:0]  w_rx_free;
  logic              w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic              r_rx_en, r_rx_ack, w_rx_ack_nxt;
  rx_state_t         r_rx_state, w_rx_state_nxt;

  logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]  r_tx_wr_ptr, r_tx_rd_ptr;
  logic [TX_CW-1:0]  r_tx_count;
  logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic              r_tx_req, w_tx_req_nxt;
  logic [DATA_W-1:0] r_tx_data;
  tx_state_t         r_tx_state, w_tx_state_nxt;

  assign w_rx_full  = (r_rx_count == RX_CW'(RX_DEPTH));
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_pop   = !w_rx_empty && in_rx_ready;
  assign w_rx_free  = RX_CW'(RX_DEPTH) - r_rx_count;

  assign w_tx_full  = (r_tx_count == TX_CW'(TX_DEPTH));
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_push  = in_tx_valid && !w_tx_full;

  // RX FIFO storage and pointers; storage itself needs no reset
  always_ff @(posedge in_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= in_rx_data;
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_rx_en     <= RX_EN_RST;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + RX_PW'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + RX_PW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + RX_CW'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - RX_CW'(1);
      r_rx_en <= (w_rx_free > RX_CW'(RX_AFULL_MARGIN));
    end
  end

  // RX handshake FSM: state register
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_rx_state <= R_IDLE;
      r_rx_ack   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_ack   <= w_rx_ack_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (in_rx_hsk_req && !w_rx_full) w_rx_state_nxt = R_ACK;
      R_ACK:   if (!in_rx_hsk_req) w_rx_state_nxt = R_IDLE;
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rx_push    = 1'b0;
    w_rx_ack_nxt = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        w_rx_push    = in_rx_hsk_req && !w_rx_full;
        w_rx_ack_nxt = in_rx_hsk_req && !w_rx_full;
      end
      R_ACK:   w_rx_ack_nxt = in_rx_hsk_req;
      default: w_rx_ack_nxt = 1'b0;
    endcase
  end

  // TX FIFO storage and pointers
  always_ff @(posedge in_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= in_tx_data;
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + TX_PW'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + TX_PW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + TX_CW'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - TX_CW'(1);
    end
  end

  // TX handshake FSM: state register plus the word held during the handshake
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_tx_state <= T_IDLE;
      r_tx_req   <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_req   <= w_tx_req_nxt;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rd_ptr];
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      T_IDLE:  if (!w_tx_empty) w_tx_state_nxt = T_REQ;
      T_REQ:   if (in_tx_hsk_ack) w_tx_state_nxt = T_DONE;
      T_DONE:  if (!in_tx_hsk_ack) w_tx_state_nxt = T_IDLE;
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop     = 1'b0;
    w_tx_req_nxt = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        w_tx_pop     = !w_tx_empty;
        w_tx_req_nxt = !w_tx_empty;
      end
      T_REQ:   w_tx_req_nxt = !in_tx_hsk_ack;
      default: w_tx_req_nxt = 1'b0;
    endcase
  end

  assign out_rx_hsk_ack = r_rx_ack;
  assign out_rx_en      = r_rx_en;
  assign out_tx_hsk_req = r_tx_req;
  assign out_tx_data    = r_tx_data;
  assign out_rx_valid   = !w_rx_empty;
  assign out_rx_data    = r_rx_mem[r_rx_rd_ptr];
  assign out_tx_ready   = !w_tx_full;
  assign out_rx_level   = r_rx_count;
  assign out_tx_level   = r_tx_count;

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Randomised bench for ftdi_fifo_bridge: the bench plays controller and user and
// compares every cycle against a queue-based model of the bridge.
module tb_ftdi_fifo_bridge;

  localparam int unsigned DW     = 8;
  localparam int unsigned RXL    = 2;
  localparam int unsigned TXL    = 3;
  localparam int unsigned MARGIN = 1;
  localparam int          RXD    = 1 << RXL;
  localparam int          TXD    = 1 << TXL;

  logic          in_clk = 1'b0;
  logic          in_reset_n;
  logic          in_rx_hsk_req;
  logic [DW-1:0] in_rx_data;
  logic          out_rx_hsk_ack;
  logic          out_rx_en;
  logic          out_tx_hsk_req;
  logic [DW-1:0] out_tx_data;
  logic          in_tx_hsk_ack;
  logic          out_rx_valid;
  logic [DW-1:0] out_rx_data;
  logic          in_rx_ready;
  logic          in_tx_valid;
  logic [DW-1:0] in_tx_data;
  logic          out_tx_ready;
  logic [RXL:0]  out_rx_level;
  logic [TXL:0]  out_tx_level;

  ftdi_fifo_bridge #(
    .DATA_W(DW), .RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL), .RX_AFULL_MARGIN(MARGIN)
  ) u_dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n),
    .in_rx_hsk_req(in_rx_hsk_req), .in_rx_data(in_rx_data),
    .out_rx_hsk_ack(out_rx_hsk_ack), .out_rx_en(out_rx_en),
    .out_tx_hsk_req(out_tx_hsk_req), .out_tx_data(out_tx_data),
    .in_tx_hsk_ack(in_tx_hsk_ack),
    .out_rx_valid(out_rx_valid), .out_rx_data(out_rx_data), .in_rx_ready(in_rx_ready),
    .in_tx_valid(in_tx_valid), .in_tx_data(in_tx_data), .out_tx_ready(out_tx_ready),
    .out_rx_level(out_rx_level), .out_tx_level(out_tx_level)
  );

  always #5 in_clk = ~in_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: FIFO contents as queues, handshake signals as protocol flags
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  logic          m_rx_ack, m_rx_en, m_tx_req;
  logic [DW-1:0] m_tx_data;
  bit            m_tx_wait_rel;
  int            tx_sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_rx_ack      = 1'b0;
    m_rx_en       = (RXD > MARGIN);
    m_tx_req      = 1'b0;
    m_tx_data     = '0;
    m_tx_wait_rel = 1'b0;
  endtask

  task automatic check_outputs();
    check("rx_ack",   32'(out_rx_hsk_ack), 32'(m_rx_ack));
    check("rx_en",    32'(out_rx_en),      32'(m_rx_en));
    check("rx_valid", 32'(out_rx_valid),   32'(rxq.size() != 0));
    check("rx_level", 32'(out_rx_level),   32'(rxq.size()));
    if (rxq.size() != 0) check("rx_data", 32'(out_rx_data), 32'(rxq[0]));
    check("tx_req",   32'(out_tx_hsk_req), 32'(m_tx_req));
    if (m_tx_req) check("tx_data", 32'(out_tx_data), 32'(m_tx_data));
    check("tx_level", 32'(out_tx_level),   32'(txq.size()));
    check("tx_ready", 32'(out_tx_ready),   32'(txq.size() < TXD));
  endtask

  // One clock: check, choose inputs for the coming edge, advance the model over it
  task automatic step(input int p_rxreq, input int p_rxrel, input int p_rdy,
                      input int p_val, input int p_ack, input int p_ackrel);
    int  rx_sz, tx_sz;
    bit  rx_push, rx_pop, tx_push;
    @(negedge in_clk);
    check_outputs();

    if (!in_rx_hsk_req && !m_rx_ack) begin
      if (chance(p_rxreq)) begin
        in_rx_hsk_req = 1'b1;
        in_rx_data    = DW'($urandom);
      end
    end else if (in_rx_hsk_req && m_rx_ack) begin
      if (chance(p_rxrel)) in_rx_hsk_req = 1'b0;
    end
    if (m_tx_req && !in_tx_hsk_ack) begin
      if (chance(p_ack)) in_tx_hsk_ack = 1'b1;
    end else if (!m_tx_req && in_tx_hsk_ack) begin
      if (chance(p_ackrel)) in_tx_hsk_ack = 1'b0;
    end
    in_rx_ready = chance(p_rdy);
    in_tx_valid = chance(p_val);
    in_tx_data  = DW'($urandom);

    rx_sz   = rxq.size();
    tx_sz   = txq.size();
    m_rx_en = (RXD - rx_sz) > MARGIN;
    rx_pop  = in_rx_ready && (rx_sz != 0);
    rx_push = !m_rx_ack && in_rx_hsk_req && (rx_sz < RXD);
    if (rx_push) m_rx_ack = 1'b1;
    else if (m_rx_ack && !in_rx_hsk_req) m_rx_ack = 1'b0;
    if (rx_pop) void'(rxq.pop_front());
    if (rx_push) rxq.push_back(in_rx_data);

    tx_push = in_tx_valid && (tx_sz < TXD);
    if (m_tx_req) begin
      if (in_tx_hsk_ack) begin
        m_tx_req      = 1'b0;
        m_tx_wait_rel = 1'b1;
        tx_sent++;
      end
    end else if (m_tx_wait_rel) begin
      if (!in_tx_hsk_ack) m_tx_wait_rel = 1'b0;
    end else if (tx_sz != 0) begin
      m_tx_data = txq.pop_front();
      m_tx_req  = 1'b1;
    end
    if (tx_push) txq.push_back(in_tx_data);
  endtask

  task automatic run(input int n, input int p_rxreq, input int p_rxrel, input int p_rdy,
                     input int p_val, input int p_ack, input int p_ackrel);
    for (int i = 0; i < n; i++) step(p_rxreq, p_rxrel, p_rdy, p_val, p_ack, p_ackrel);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rx_ack"},   32'(out_rx_hsk_ack), 32'(0));
    check({pfx, "_tx_req"},   32'(out_tx_hsk_req), 32'(0));
    check({pfx, "_tx_data"},  32'(out_tx_data),    32'(0));
    check({pfx, "_rx_valid"}, 32'(out_rx_valid),   32'(0));
    check({pfx, "_rx_level"}, 32'(out_rx_level),   32'(0));
    check({pfx, "_tx_level"}, 32'(out_tx_level),   32'(0));
    check({pfx, "_tx_ready"}, 32'(out_tx_ready),   32'(1));
    check({pfx, "_rx_en"},    32'(out_rx_en),      32'(1));
  endtask

  task automatic idle_inputs();
    in_rx_hsk_req = 1'b0;
    in_rx_data    = '0;
    in_tx_hsk_ack = 1'b0;
    in_rx_ready   = 1'b0;
    in_tx_valid   = 1'b0;
    in_tx_data    = '0;
  endtask

  initial begin
    bit hit;
    tx_sent    = 0;
    in_reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge in_clk);
    in_reset_n = 1'b1;

    run(600, 50, 50, 50, 50, 50, 50);
    run(400, 80, 60,  5, 90,  5, 50);
    run(400, 100, 100, 100, 60, 100, 100);
    run(300, 70, 40, 30, 20, 60, 60);

    // Hold off TX acks and RX pops until a TX word is in handshake and RX holds 3
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(100, 100, 0, 100, 0, 100);
      hit = m_tx_req && (rxq.size() >= 3);
    end
    check("rst_cond_reached", 32'(hit), 32'(1));
    @(posedge in_clk);
    #1;
    check("pre_rst_tx_req", 32'(out_tx_hsk_req), 32'(m_tx_req));
    #1;
    in_reset_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_values("mid_rst");
    model_reset();
    @(negedge in_clk);
    in_reset_n = 1'b1;

    run(400, 50, 50, 50, 50, 50, 50);
    check("tx_words_moved", 32'(tx_sent > 20), 32'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
